// File: rtl/crypto_key_loader.sv
// Byte-stream key loader: collects low/high key bytes plus a check byte, verifies it,
// and emits a single registered write strobe toward the key store before optionally locking.
module crypto_key_loader #(
  parameter int                 BYTE_W       = 8,
  parameter int                 KEY_W        = 2 * BYTE_W,
  parameter logic [BYTE_W-1:0]  CHK_CONST    = 8'hA5,
  parameter bit                 LOCK_ON_LOAD = 1'b1,
  parameter int unsigned        MAX_FAIL     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              clear,
  output logic [KEY_W-1:0]  key_data,
  output logic              key_write_en,
  output logic              locked,
  output logic              error,
  output logic [3:0]        fail_cnt
);

  localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_LO,
    S_GOT_HI,
    S_WRITE,
    S_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  lo_q, lo_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [KEY_W-1:0]   key_data_q, key_data_d;
  logic               key_write_en_q, key_write_en_d;
  logic               error_q, error_d;
  logic [3:0]         fail_cnt_q, fail_cnt_d;
  logic               accept;
  logic [3:0]         fail_inc;

  assign byte_ready = !reset &&
                      ((state_q == S_IDLE) || (state_q == S_GOT_LO) || (state_q == S_GOT_HI));
  assign accept     = byte_valid && byte_ready;
  assign fail_inc   = (fail_cnt_q < MAX_FAIL_C) ? (fail_cnt_q + 4'd1) : fail_cnt_q;

  always_comb begin
    state_d        = state_q;
    lo_d           = lo_q;
    hi_d           = hi_q;
    key_data_d     = '0;
    key_write_en_d = 1'b0;
    error_d        = error_q;
    fail_cnt_d     = fail_cnt_q;

    case (state_q)
      S_IDLE, S_GOT_LO, S_GOT_HI: begin
        // clear wins over a byte presented in the same cycle
        if (clear) begin
          state_d = S_IDLE;
          lo_d    = '0;
          hi_d    = '0;
        end else if (accept) begin
          case (state_q)
            S_IDLE: begin
              lo_d    = byte_in;
              state_d = S_GOT_LO;
            end
            S_GOT_LO: begin
              hi_d    = byte_in;
              state_d = S_GOT_HI;
            end
            default: begin
              if (byte_in == (lo_q ^ hi_q ^ CHK_CONST)) begin
                key_write_en_d = 1'b1;
                key_data_d     = {hi_q, lo_q};
                state_d        = S_WRITE;
              end else begin
                error_d    = 1'b1;
                fail_cnt_d = fail_inc;
                lo_d       = '0;
                hi_d       = '0;
                state_d    = (fail_inc == MAX_FAIL_C) ? S_LOCKED : S_IDLE;
              end
            end
          endcase
        end
      end
      S_WRITE: begin
        // the strobe already went out; clear only redirects where we land afterwards
        lo_d    = '0;
        hi_d    = '0;
        state_d = (LOCK_ON_LOAD && !clear) ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_IDLE;
        lo_d    = '0;
        hi_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lo_q           <= '0;
      hi_q           <= '0;
      key_data_q     <= '0;
      key_write_en_q <= 1'b0;
      error_q        <= 1'b0;
      fail_cnt_q     <= 4'd0;
    end else begin
      state_q        <= state_d;
      lo_q           <= lo_d;
      hi_q           <= hi_d;
      key_data_q     <= key_data_d;
      key_write_en_q <= key_write_en_d;
      error_q        <= error_d;
      fail_cnt_q     <= fail_cnt_d;
    end
  end

  assign key_data     = key_data_q;
  assign key_write_en = key_write_en_q;
  assign locked       = (state_q == S_LOCKED);
  assign error        = error_q;
  assign fail_cnt     = fail_cnt_q;

endmodule
